// File: rtl/placar_pkg.sv
// -----------------------------------------------------------------------------
// placar_pkg
// Shared types and constants for the scoreboard controller.
//   state_t            : controller FSM states
//   PTS_A/PTS_B/PTS_C  : point values of the three buttons
//   DEFAULT_MAX_SCORE  : highest score a two-digit display can show
//   encode_pts()       : one-hot button press to 2-bit point value
// -----------------------------------------------------------------------------
package placar_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      COMMIT,
      WAIT_REL
   } state_t;

   localparam logic [1:0] PTS_A = 2'd1;
   localparam logic [1:0] PTS_B = 2'd2;
   localparam logic [1:0] PTS_C = 2'd3;

   localparam int unsigned DEFAULT_MAX_SCORE = 99;

   // Only meaningful when exactly one press is set; priority keeps it total.
   function automatic logic [1:0] encode_pts(input logic a, input logic b, input logic c);
      logic [1:0] pts;
      pts = 2'd0;
      if (a) begin
         pts = PTS_A;
      end else if (b) begin
         pts = PTS_B;
      end else if (c) begin
         pts = PTS_C;
      end
      return pts;
   endfunction

endpackage

// File: rtl/debounce_botao.sv
// -----------------------------------------------------------------------------
// debounce_botao
// Synchronizes and debounces one raw active-low push button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button, active-low, asynchronous to clk
//   level      : debounced level, 1 = pressed (reset: released)
//   press      : one-cycle pulse on the debounced released-to-pressed edge,
//                coincident with the first cycle level reads 1
// -----------------------------------------------------------------------------
module debounce_botao
   import placar_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]      sync_q;
   logic            sample;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            press_q;

   // Raw input is active-low; work in pressed=1 after the synchronizer.
   assign sample = ~sync_q[1];

   // cnt_q counts consecutive samples that disagree with the debounced level;
   // any agreeing sample restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sample != level_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sample;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= level_d & ~level_q;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/placar_controle.sv
// -----------------------------------------------------------------------------
// placar_controle
// Sequential front end of the scoreboard: debounces the point buttons, feeds
// the external adder/subtractor and commits its result to the team register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   btn_a/btn_b/btn_c     : raw active-low buttons worth 1/2/3 points
//   btn_zerar             : raw active-low clear button (PLACAR_ZERAR_EN only)
//   sub_mode, team_sel    : operation and team, sampled at the press
//   pontos_btn            : point value to adder B input, 0 when idle
//   pontos_atual          : selected team score to adder N1 input
//   soma_in               : adder result
//   placar_time0/1        : registered team scores
//   buzzer                : error pulse, BUZZER_CYCLES long
//   led                   : high while an operation is in progress
// Optional feature macro: PLACAR_ZERAR_EN adds btn_zerar, which clears both
// scores from IDLE.
// -----------------------------------------------------------------------------
module placar_controle
   import placar_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SCORE_W         = 7,
   parameter int unsigned MAX_SCORE       = DEFAULT_MAX_SCORE,
   parameter int unsigned BUZZER_CYCLES   = 25000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_a,
   input  logic               btn_b,
   input  logic               btn_c,
`ifdef PLACAR_ZERAR_EN
   input  logic               btn_zerar,
`endif
   input  logic               sub_mode,
   input  logic               team_sel,
   output logic [1:0]         pontos_btn,
   output logic [SCORE_W-1:0] pontos_atual,
   input  logic [SCORE_W-1:0] soma_in,
   output logic [SCORE_W-1:0] placar_time0,
   output logic [SCORE_W-1:0] placar_time1,
   output logic               buzzer,
   output logic               led
);

   localparam int unsigned SumW = SCORE_W + 1;
   localparam int unsigned BzW  = $clog2(BUZZER_CYCLES + 1);
   localparam logic [SumW-1:0] MaxVal = SumW'(MAX_SCORE);

   state_t             state_q, state_d;
   logic [1:0]         pts_q, pts_d;
   logic               team_q, team_d;
   logic               mode_q, mode_d;
   logic [SCORE_W-1:0] score0_q, score0_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [BzW-1:0]     buzz_q, buzz_d;
   logic               buzz_start;

   logic lvl_a, lvl_b, lvl_c;
   logic prs_a, prs_b, prs_c;
   logic zerar_press;
   logic [1:0] n_press;

   logic               cur_team;
   logic [SCORE_W-1:0] cur_score;
   logic [SumW-1:0]    pts_ext, sum_ext;
   logic               valid;

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_a),
      .level (lvl_a),
      .press (prs_a)
   );

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_b),
      .level (lvl_b),
      .press (prs_b)
   );

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_c),
      .level (lvl_c),
      .press (prs_c)
   );

`ifdef PLACAR_ZERAR_EN
   logic lvl_z;

   // Clear acts on the press edge only; the held level is irrelevant.
   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_z (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_zerar),
      .level (lvl_z),
      .press (zerar_press)
   );

   logic unused_lvl_z;
   assign unused_lvl_z = lvl_z;
`else
   assign zerar_press = 1'b0;
`endif

   assign n_press = 2'(prs_a) + 2'(prs_b) + 2'(prs_c);

   // In IDLE the adder input tracks team_sel live; afterwards the latched team.
   assign cur_team  = (state_q == IDLE) ? team_sel : team_q;
   assign cur_score = cur_team ? score1_q : score0_q;

   // Validity is decided here in SCORE_W+1 bits so the adder carry is not needed.
   assign pts_ext = SumW'(pts_q);
   assign sum_ext = {1'b0, cur_score} + pts_ext;
   assign valid   = mode_q ? (pts_ext <= {1'b0, cur_score}) : (sum_ext <= MaxVal);

   always_comb begin
      state_d    = state_q;
      pts_d      = pts_q;
      team_d     = team_q;
      mode_d     = mode_q;
      score0_d   = score0_q;
      score1_d   = score1_q;
      buzz_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (zerar_press) begin
               score0_d = '0;
               score1_d = '0;
            end else if (n_press == 2'd1) begin
               pts_d   = encode_pts(prs_a, prs_b, prs_c);
               team_d  = team_sel;
               mode_d  = sub_mode;
               state_d = APPLY;
            end else if (n_press >= 2'd2) begin
               buzz_start = 1'b1;
               state_d    = WAIT_REL;
            end
         end
         APPLY: begin
            state_d = COMMIT;
         end
         COMMIT: begin
            if (valid) begin
               if (team_q) begin
                  score1_d = soma_in;
               end else begin
                  score0_d = soma_in;
               end
            end else begin
               buzz_start = 1'b1;
            end
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!lvl_a && !lvl_b && !lvl_c) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A start while the buzzer runs simply reloads the full length.
   always_comb begin
      buzz_d = buzz_q;
      if (buzz_start) begin
         buzz_d = BzW'(BUZZER_CYCLES);
      end else if (buzz_q != '0) begin
         buzz_d = buzz_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pts_q    <= 2'd0;
         team_q   <= 1'b0;
         mode_q   <= 1'b0;
         score0_q <= '0;
         score1_q <= '0;
         buzz_q   <= '0;
      end else begin
         state_q  <= state_d;
         pts_q    <= pts_d;
         team_q   <= team_d;
         mode_q   <= mode_d;
         score0_q <= score0_d;
         score1_q <= score1_d;
         buzz_q   <= buzz_d;
      end
   end

   assign pontos_btn   = ((state_q == APPLY) || (state_q == COMMIT)) ? pts_q : 2'd0;
   assign pontos_atual = cur_score;
   assign placar_time0 = score0_q;
   assign placar_time1 = score1_q;
   assign buzzer       = (buzz_q != '0);
   assign led          = (state_q != IDLE);

endmodule

// File: tb/tb_placar_controle.sv
// -----------------------------------------------------------------------------
// tb_placar_controle
// Directed self-checking bench for placar_controle with short debounce and
// buzzer lengths. soma_in is driven by a behavioural adder/subtractor.
// -----------------------------------------------------------------------------
module tb_placar_controle;

   localparam int unsigned DB   = 8;
   localparam int unsigned BZ   = 20;
   localparam int unsigned SW   = 7;
   localparam int unsigned MAXS = 99;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          btn_a = 1'b1;
   logic          btn_b = 1'b1;
   logic          btn_c = 1'b1;
`ifdef PLACAR_ZERAR_EN
   logic          btn_zerar = 1'b1;
`endif
   logic          sub_mode = 1'b0;
   logic          team_sel = 1'b0;
   logic [1:0]    pontos_btn;
   logic [SW-1:0] pontos_atual;
   logic [SW-1:0] soma_in;
   logic [SW-1:0] placar_time0;
   logic [SW-1:0] placar_time1;
   logic          buzzer;
   logic          led;

   int checks = 0;
   int passed = 0;
   int pb_cnt = 0;
   int bz_cnt = 0;
   int led_rise = 0;
   logic led_prev = 1'b0;

   placar_controle #(
      .DEBOUNCE_CYCLES (DB),
      .SCORE_W         (SW),
      .MAX_SCORE       (MAXS),
      .BUZZER_CYCLES   (BZ)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_a        (btn_a),
      .btn_b        (btn_b),
      .btn_c        (btn_c),
`ifdef PLACAR_ZERAR_EN
      .btn_zerar    (btn_zerar),
`endif
      .sub_mode     (sub_mode),
      .team_sel     (team_sel),
      .pontos_btn   (pontos_btn),
      .pontos_atual (pontos_atual),
      .soma_in      (soma_in),
      .placar_time0 (placar_time0),
      .placar_time1 (placar_time1),
      .buzzer       (buzzer),
      .led          (led)
   );

   always #5 clk = ~clk;

   // External adder/subtractor, wrapping modulo 2^SW like the real one.
   always_comb begin
      soma_in = sub_mode ? (pontos_atual - SW'(pontos_btn)) : (pontos_atual + SW'(pontos_btn));
   end

   always @(negedge clk) begin
      if (pontos_btn != 2'd0) pb_cnt++;
      if (buzzer === 1'b1) bz_cnt++;
      if (led === 1'b1 && led_prev !== 1'b1) led_rise++;
      led_prev = led;
   end

   task automatic drive_btns(input logic a, input logic b, input logic c);
      btn_a = ~a;
      btn_b = ~b;
      btn_c = ~c;
   endtask

   // One full operation: hold well past debounce, release, wait for IDLE.
   task automatic press(input logic a, input logic b, input logic c,
                        input logic team, input logic sub);
      team_sel = team;
      sub_mode = sub;
      drive_btns(a, b, c);
      repeat (20) @(negedge clk);
      drive_btns(1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (placar_time0 !== 7'd0) $display("FAIL reset_time0: got %0d want 0", placar_time0);
      else passed++;
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL reset_time1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (pontos_btn !== 2'd0) $display("FAIL reset_pontos_btn: got %0d want 0", pontos_btn);
      else passed++;
      checks++;
      if (buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b want 0", buzzer);
      else passed++;
      checks++;
      if (led !== 1'b0) $display("FAIL reset_led: got %b want 0", led);
      else passed++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_add;
      int pb0, bz0;
      pb0 = pb_cnt;
      bz0 = bz_cnt;
      team_sel = 1'b0;
      sub_mode = 1'b0;
      drive_btns(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (led === 1'b1) break;
         @(negedge clk);
      end
      checks++;
      if (led !== 1'b1) $display("FAIL add_apply_reached: led %b want 1", led);
      else passed++;
      // APPLY cycle
      checks++;
      if (pontos_btn !== 2'd2) $display("FAIL add_apply_pts: got %0d want 2", pontos_btn);
      else passed++;
      checks++;
      if (placar_time0 !== 7'd0) $display("FAIL add_apply_score: got %0d want 0", placar_time0);
      else passed++;
      // team_sel change after the latch must not redirect the result
      team_sel = 1'b1;
      @(negedge clk);
      checks++;
      if (pontos_btn !== 2'd2) $display("FAIL add_commit_pts: got %0d want 2", pontos_btn);
      else passed++;
      checks++;
      if (placar_time0 !== 7'd0) $display("FAIL add_commit_score: got %0d want 0", placar_time0);
      else passed++;
      @(negedge clk);
      checks++;
      if (placar_time0 !== 7'd2) $display("FAIL add_result: got %0d want 2", placar_time0);
      else passed++;
      checks++;
      if (pontos_btn !== 2'd0) $display("FAIL add_waitrel_pts: got %0d want 0", pontos_btn);
      else passed++;
      repeat (16) @(negedge clk);
      drive_btns(1'b0, 1'b0, 1'b0);
      team_sel = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL add_other_team: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (pb_cnt - pb0 !== 2) $display("FAIL add_pts_cycles: got %0d want 2", pb_cnt - pb0);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== 0) $display("FAIL add_no_buzzer: got %0d want 0", bz_cnt - bz0);
      else passed++;
      checks++;
      if (led !== 1'b0) $display("FAIL add_back_idle: led %b want 0", led);
      else passed++;
   endtask

   task automatic test_bounce;
      int l0;
      l0 = led_rise;
      for (int i = 0; i < 10; i++) begin
         btn_a = ~btn_a;
         repeat (3) @(negedge clk);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (placar_time0 !== 7'd3) $display("FAIL bounce_score: got %0d want 3", placar_time0);
      else passed++;
      checks++;
      if (led_rise - l0 !== 1) $display("FAIL bounce_ops: got %0d want 1", led_rise - l0);
      else passed++;
   endtask

   task automatic test_add_limits;
      int bz0;
      for (int i = 0; i < 31; i++) press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (placar_time0 !== 7'd97) $display("FAIL lim_setup97: got %0d want 97", placar_time0);
      else passed++;
      bz0 = bz_cnt;
      press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (placar_time0 !== 7'd97) $display("FAIL lim_97p3: got %0d want 97", placar_time0);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== BZ) $display("FAIL lim_97p3_buzz: got %0d want %0d", bz_cnt - bz0, BZ);
      else passed++;
      press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (placar_time0 !== 7'd99) $display("FAIL lim_97p2: got %0d want 99", placar_time0);
      else passed++;
      bz0 = bz_cnt;
      press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (placar_time0 !== 7'd99) $display("FAIL lim_99p1: got %0d want 99", placar_time0);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== BZ) $display("FAIL lim_99p1_buzz: got %0d want %0d", bz_cnt - bz0, BZ);
      else passed++;
      for (int i = 0; i < 32; i++) press(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (placar_time1 !== 7'd96) $display("FAIL lim_setup96: got %0d want 96", placar_time1);
      else passed++;
      bz0 = bz_cnt;
      press(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (placar_time1 !== 7'd99) $display("FAIL lim_96p3: got %0d want 99", placar_time1);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== 0) $display("FAIL lim_96p3_buzz: got %0d want 0", bz_cnt - bz0);
      else passed++;
   endtask

   task automatic test_sub_limits;
      int bz0;
      for (int i = 0; i < 32; i++) press(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      press(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (placar_time1 !== 7'd1) $display("FAIL sub_setup1: got %0d want 1", placar_time1);
      else passed++;
      bz0 = bz_cnt;
      press(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (placar_time1 !== 7'd1) $display("FAIL sub_1m2: got %0d want 1", placar_time1);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== BZ) $display("FAIL sub_1m2_buzz: got %0d want %0d", bz_cnt - bz0, BZ);
      else passed++;
      press(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL sub_1m1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (placar_time0 !== 7'd99) $display("FAIL sub_team0_kept: got %0d want 99", placar_time0);
      else passed++;
      sub_mode = 1'b0;
   endtask

   task automatic test_double_press;
      int bz0, l0;
      bz0 = bz_cnt;
      l0 = led_rise;
      team_sel = 1'b1;
      sub_mode = 1'b0;
      drive_btns(1'b1, 1'b0, 1'b1);
      repeat (45) @(negedge clk);
      drive_btns(1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL dbl_time1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (placar_time0 !== 7'd99) $display("FAIL dbl_time0: got %0d want 99", placar_time0);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== BZ) $display("FAIL dbl_buzz: got %0d want %0d", bz_cnt - bz0, BZ);
      else passed++;
      checks++;
      if (led_rise - l0 !== 1) $display("FAIL dbl_ops: got %0d want 1", led_rise - l0);
      else passed++;
   endtask

   task automatic test_reset_mid;
      team_sel = 1'b1;
      sub_mode = 1'b0;
      drive_btns(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (led === 1'b1) break;
         @(negedge clk);
      end
      checks++;
      if (led !== 1'b1) $display("FAIL rmid_apply_reached: led %b want 1", led);
      else passed++;
      @(negedge clk);
      checks++;
      if (pontos_btn !== 2'd1) $display("FAIL rmid_commit_pts: got %0d want 1", pontos_btn);
      else passed++;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (placar_time0 !== 7'd0) $display("FAIL rmid_time0: got %0d want 0", placar_time0);
      else passed++;
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL rmid_time1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (pontos_btn !== 2'd0) $display("FAIL rmid_pts: got %0d want 0", pontos_btn);
      else passed++;
      checks++;
      if (led !== 1'b0) $display("FAIL rmid_led: got %b want 0", led);
      else passed++;
      checks++;
      if (buzzer !== 1'b0) $display("FAIL rmid_buzzer: got %b want 0", buzzer);
      else passed++;
      drive_btns(1'b0, 1'b0, 1'b0);
      repeat (15) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL rmid_after_time1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (led !== 1'b0) $display("FAIL rmid_after_led: got %b want 0", led);
      else passed++;
      team_sel = 1'b0;
   endtask

`ifdef PLACAR_ZERAR_EN
   task automatic test_zerar;
      int bz0;
      press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (placar_time0 !== 7'd2) $display("FAIL zer_setup0: got %0d want 2", placar_time0);
      else passed++;
      checks++;
      if (placar_time1 !== 7'd1) $display("FAIL zer_setup1: got %0d want 1", placar_time1);
      else passed++;
      bz0 = bz_cnt;
      btn_zerar = 1'b0;
      repeat (20) @(negedge clk);
      btn_zerar = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (placar_time0 !== 7'd0) $display("FAIL zer_time0: got %0d want 0", placar_time0);
      else passed++;
      checks++;
      if (placar_time1 !== 7'd0) $display("FAIL zer_time1: got %0d want 0", placar_time1);
      else passed++;
      checks++;
      if (bz_cnt - bz0 !== 0) $display("FAIL zer_buzz: got %0d want 0", bz_cnt - bz0);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_add();
      test_bounce();
      test_add_limits();
      test_sub_limits();
      test_double_press();
      test_reset_mid();
`ifdef PLACAR_ZERAR_EN
      test_zerar();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
